// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter slice.
// UART_TX_PARITY_EN adds the PARITY state (8E1 framing).
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;
`endif

endpackage

// File: rtl/uart_tx_if.sv
// Core-side byte-write port of the UART transmitter.
// LW must equal FIFO_DEPTH_LOG2 + 1 of the attached uart_tx.
interface uart_tx_if #(
    parameter int LW = 5
);
    logic [31:0]   din;
    logic          we;
    logic          full;
    logic [LW-1:0] level;
    logic          overflow;

    modport master (
        output din, we,
        input  full, level, overflow
    );

    modport slave (
        input  din, we,
        output full, level, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Register-array write FIFO buffering bytes ahead of the serialiser.
// level_nxt exposes next-cycle occupancy so busy can be registered.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic [DEPTH_LOG2:0]   level_nxt
);
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [LW-1:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  push_ok, pop_ok;

    assign full    = (level_q == FULL_LVL);
    assign empty   = (level_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;
    assign level_nxt = level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        unique case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter fed by the core's byte-write strobe.
// Define UART_TX_PARITY_EN for 8E1 (even parity bit before stop).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT    = 868,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    uart_tx_if.slave   wr,
    output logic       txd,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int LW = FIFO_DEPTH_LOG2 + 1;
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

    uart_tx_state_t            state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      txd_q, txd_d;
    logic                      busy_q, busy_d;
    logic                      ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
    logic                      par_q, par_d;
`endif

    logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]                fifo_rdata;
    logic [LW-1:0]             fifo_level, fifo_level_nxt;
    logic                      last, load;
    logic                      din_unused;

    assign din_unused = ^wr.din[31:8];
    assign fifo_push  = wr.we && !fifo_full;

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .wdata     (wr.din[7:0]),
        .pop       (fifo_pop),
        .rdata     (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .level_nxt (fifo_level_nxt)
    );

    assign last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        load     = 1'b0;
        fifo_pop = 1'b0;
        if (state_q != IDLE) cnt_d = last ? '0 : cnt_q + CW'(1);
        unique case (state_q)
            IDLE: load = !fifo_empty;
            START: if (last) begin
                state_d = DATA;
                txd_d   = shift_q[0];
            end
            DATA: if (last) begin
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
                    txd_d   = par_q;
`else
                    state_d = STOP;
                    txd_d   = 1'b1;
`endif
                end else begin
                    idx_d   = idx_q + IW'(1);
                    shift_d = shift_q >> 1;
                    txd_d   = shift_q[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (last) begin
                state_d = STOP;
                txd_d   = 1'b1;
            end
`endif
            // Refill straight from the FIFO keeps back-to-back frames gapless.
            STOP: if (last) begin
                if (!fifo_empty) load = 1'b1;
                else state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = START;
            cnt_d    = '0;
            txd_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d    = ^fifo_rdata;
`endif
        end
    end

    assign ovf_d  = ovf_q || (wr.we && fifo_full);
    assign busy_d = (state_d != IDLE) || (fifo_level_nxt != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign txd         = txd_q;
    assign busy        = busy_q;
    assign wr.full     = fifo_full;
    assign wr.level    = fifo_level;
    assign wr.overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: idle, single frame, bursts, overflow, abort.
// Build with UART_TX_PARITY_EN to also check the 8E1 frame.
module tb_uart_tx;

    localparam int CPB = 4;
    localparam int DL2 = 2;
    localparam int LW  = DL2 + 1;

    logic clk = 1'b0;
    logic reset;
    logic txd;
    logic busy;

    uart_tx_if #(.LW(LW)) wr_if ();

    uart_tx #(
        .CLKS_PER_BIT    (CPB),
        .FIFO_DEPTH_LOG2 (DL2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .wr    (wr_if),
        .txd   (txd),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic nedge(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input logic [7:0] b);
        wr_if.we  = 1'b1;
        wr_if.din = {24'hC0FFEE, b};
        nedge(1);
    endtask

    task automatic wait_fall(input string tag);
        int i;
        i = 0;
        while (txd !== 1'b0 && i < 200) begin
            nedge(1);
            i++;
        end
        chk({tag, "_start_seen"}, {31'd0, txd}, 32'd0);
    endtask

    // Entered half a cycle into the start bit; leaves half a cycle
    // into the bit period following the stop bit.
    task automatic rx_frame(input string tag, input logic [7:0] exp);
        logic [7:0] d;
        logic       s0;
        logic       st;
        nedge(1);
        s0 = txd;
        for (int i = 0; i < 8; i++) begin
            nedge(CPB);
            d[i] = txd;
        end
`ifdef UART_TX_PARITY_EN
        nedge(CPB);
        chk({tag, "_parity"}, {31'd0, txd}, {31'd0, ^exp});
`endif
        nedge(CPB);
        st = txd;
        nedge(2);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd1);
        nedge(1);
        chk({tag, "_startbit"}, {31'd0, s0}, 32'd0);
        chk({tag, "_data"}, {24'd0, d}, {24'd0, exp});
        chk({tag, "_stopbit"}, {31'd0, st}, 32'd1);
    endtask

    task automatic watch_quiet(input string tag, input int n);
        logic any_low;
        any_low = 1'b0;
        for (int i = 0; i < n; i++) begin
            nedge(1);
            if (txd !== 1'b1) any_low = 1'b1;
        end
        chk({tag, "_no_tx"}, {31'd0, any_low}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wr_if.we  = 1'b0;
        wr_if.din = '0;
        reset     = 1'b0;
        nedge(3);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_level", {29'd0, wr_if.level}, 32'd0);
        chk("rst_full", {31'd0, wr_if.full}, 32'd0);
        chk("rst_ovf", {31'd0, wr_if.overflow}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            nedge(10);
            chk("idle_txd", {31'd0, txd}, 32'd1);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_level", {29'd0, wr_if.level}, 32'd0);
        end

        // Single byte from idle
        put(8'hA5);
        wr_if.we = 1'b0;
        chk("a5_level", {29'd0, wr_if.level}, 32'd1);
        chk("a5_txd_hold", {31'd0, txd}, 32'd1);
        chk("a5_busy", {31'd0, busy}, 32'd1);
        nedge(1);
        chk("a5_txd_fall", {31'd0, txd}, 32'd0);
        rx_frame("a5", 8'hA5);
        chk("a5_busy_off", {31'd0, busy}, 32'd0);
        nedge(5);

        // Lead frame occupies the FSM while four bytes fill the FIFO
        fork
            begin
                put(8'hFF);
                for (int k = 1; k <= 4; k++) put(8'(k));
                wr_if.we = 1'b0;
                chk("b4_full", {31'd0, wr_if.full}, 32'd1);
                chk("b4_level", {29'd0, wr_if.level}, 32'd4);
                chk("b4_ovf", {31'd0, wr_if.overflow}, 32'd0);
            end
            begin
                wait_fall("b4");
                rx_frame("b4_lead", 8'hFF);
                for (int k = 1; k <= 4; k++) begin
                    chk("b4_gap", {31'd0, txd}, 32'd0);
                    rx_frame("b4_byte", 8'(k));
                end
                chk("b4_busy_off", {31'd0, busy}, 32'd0);
                chk("b4_ovf_end", {31'd0, wr_if.overflow}, 32'd0);
            end
        join
        nedge(5);

        // Six writes into a four-deep FIFO: 0x14 and 0x15 are dropped
        fork
            begin
                put(8'h55);
                for (int k = 0; k < 6; k++) put(8'h10 + 8'(k));
                wr_if.we = 1'b0;
                chk("ov_ovf", {31'd0, wr_if.overflow}, 32'd1);
                chk("ov_level", {29'd0, wr_if.level}, 32'd4);
                chk("ov_full", {31'd0, wr_if.full}, 32'd1);
            end
            begin
                wait_fall("ov");
                rx_frame("ov_lead", 8'h55);
                for (int k = 0; k < 4; k++) begin
                    chk("ov_gap", {31'd0, txd}, 32'd0);
                    rx_frame("ov_byte", 8'h10 + 8'(k));
                end
                chk("ov_busy_off", {31'd0, busy}, 32'd0);
            end
        join
        watch_quiet("ov", 30);
        chk("ov_sticky", {31'd0, wr_if.overflow}, 32'd1);
        chk("ov_level_end", {29'd0, wr_if.level}, 32'd0);

        // Abort mid-frame: 0x30 has data bit 1 low, in flight 9 cycles in
        put(8'h30);
        put(8'h44);
        put(8'h66);
        wr_if.we = 1'b0;
        chk("ab_level", {29'd0, wr_if.level}, 32'd2);
        nedge(8);
        chk("ab_pre_txd", {31'd0, txd}, 32'd0);
        reset = 1'b0;
        #1;
        chk("ab_txd", {31'd0, txd}, 32'd1);
        chk("ab_level0", {29'd0, wr_if.level}, 32'd0);
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_ovf_clr", {31'd0, wr_if.overflow}, 32'd0);
        nedge(2);
        reset = 1'b1;
        watch_quiet("ab", 60);
        chk("ab_busy_end", {31'd0, busy}, 32'd0);
        chk("ab_level_end", {29'd0, wr_if.level}, 32'd0);

`ifdef UART_TX_PARITY_EN
        put(8'h07);
        wr_if.we = 1'b0;
        wait_fall("par");
        rx_frame("par", 8'h07);
        chk("par_busy_off", {31'd0, busy}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter consuming the core's `uart_dout`/`uart_we` byte-write strobe and driving an 8N1 (optionally 8E1) line on `txd`. A write FIFO absorbs bursts of stores so the core is never stalled. Sits at top level beside `core`; its `din`/`we` connect directly to `uart_dout`/`uart_we`.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per bit period, ≥ 2 (115200 baud at 100 MHz).
- `FIFO_DEPTH_LOG2`, 4: FIFO holds 2**FIFO_DEPTH_LOG2 bytes.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: **asynchronous, active-low** reset. One clock; reset is asynchronous and active-low.
- `din` input 32: write data; only `din[7:0]` is transmitted, `din[31:8]` ignored.
- `we` input 1: write strobe, one byte per cycle high.
- `txd` output 1: serial line, idle high.
- `busy` output 1: high while the FIFO is non-empty or a frame is in flight.
- `full` output 1: FIFO full (registered count == depth).
- `level` output FIFO_DEPTH_LOG2+1: FIFO occupancy.
- `overflow` output 1: sticky; set when a write is dropped, cleared only by reset.

## Operation
- Reset values: `txd`=1, `busy`=0, `full`=0, `level`=0, `overflow`=0, FSM in IDLE, baud counter 0, bit index 0.
- Write: `we`=1 and not `full` pushes `din[7:0]`. `we`=1 while `full` drops the byte and sets `overflow`. `full` is evaluated on the pre-edge count, so a write coinciding with a pop while full is still dropped.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: if FIFO non-empty, pop into the shift register, go to START, and drive `txd`=0. Otherwise hold `txd`=1.
- START/DATA/PARITY/STOP: each bit lasts exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances.
- DATA: 8 bits, LSB first. The bit index runs 0..7 and resets to 0 on leaving DATA.
- STOP: `txd`=1. At the end of the stop bit, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Simultaneous push and pop when not full: `level` is unchanged and both take effect.
- Asserting `reset` mid-frame aborts immediately: `txd`=1 and the FIFO is emptied.

## Timing
- `we` sampled at edge N: byte is in the FIFO after edge N and `level`=1. If IDLE, edge N+1 pops it and `txd` falls after edge N+1.
- Frame length 10×CLKS_PER_BIT cycles (11× with parity). Back-to-back frames are contiguous.
- All outputs are registered. `busy` falls on the same edge the FSM enters IDLE with an empty FIFO.
- Peak write rate of 1 per cycle is tolerated up to FIFO depth. Sustained throughput is 1 byte per frame.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state is inserted between DATA and STOP. It transmits even parity (XOR of the 8 data bits) for one bit period. Frame = 11 bit periods.
- Undefined: no PARITY state, the encoding is absent, and frame = 10 bit periods (8N1).

## Structure
- Package `uart_pkg`: `uart_tx_state_t` enum (IDLE, START, DATA, PARITY, STOP) and `UART_DATA_BITS` = 8.
- Sub-module `sync_fifo` (width 8, depth parameter): provides push/pop, `full`, `empty` and `level`. Storage is a register array.
- `uart_tx` holds the FSM, the baud counter, the shift register, the parity register and the overflow flag.

## Test plan
- Bench uses CLKS_PER_BIT=4, FIFO_DEPTH_LOG2=2.
- Reset release, no writes → `txd`=1, `busy`=0, `level`=0 for 100 cycles.
- Single write `din`=0x0000_00A5 → `txd` falls 2 edges after `we`. Sampling mid-bit yields 0,1,0,1,0,0,1,0,1,1 (start, LSB-first 0xA5, stop), each held 4 cycles; `busy` falls after 40 cycles.
- Burst of 4 writes 0x01..0x04 on consecutive cycles → `full`=1, `level`=4. Four contiguous frames with no idle gap; `overflow`=0.
- Burst of 6 writes 0x10..0x15 → bytes 0x14 and 0x15 are dropped, `overflow`=1 and stays set. Only 0x10..0x13 appear on `txd`.
- Reset asserted 9 cycles into a frame, queue holding 2 bytes → `txd`=1 immediately and `level`=0. After release, nothing is transmitted.
- With `UART_TX_PARITY_EN`, write 0x07 → parity bit 1 after bit 7, then stop. Frame is 44 cycles.
